// File: rtl/axis_relu_maxpool.sv
// rtl/axis_relu_maxpool.sv - streaming ReLU and 1-D max-pool stage with frame TLAST checking
module axis_relu_maxpool #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 512,
    parameter int NUM_ROWS   = 8,
    parameter int POOL_SIZE  = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  FRAME_ERR
);
    localparam int COLS = ROW_LEN / POOL_SIZE;
    localparam int WW   = $clog2(POOL_SIZE);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [WW-1:0] WIN_MAX = WW'(POOL_SIZE - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state;
    logic [WW-1:0]         win_cnt;
    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  frame_err;
    logic [DATA_WIDTH-1:0] relu_x;
    logic [DATA_WIDTH-1:0] cur_max;
    logic                  in_beat;
    logic                  out_beat;
    logic                  win_last;
    logic                  col_last;
    logic                  row_last;
    logic                  frame_last;
    logic                  early_last;

    // After ReLU both operands are non-negative, so an unsigned compare equals the signed one
    assign relu_x  = S_AXIS_TDATA[DATA_WIDTH-1] ? '0 : S_AXIS_TDATA;
    assign cur_max = ((win_cnt == '0) || (relu_x > acc)) ? relu_x : acc;

    assign win_last   = (win_cnt == WIN_MAX);
    assign col_last   = (col_cnt == COL_MAX);
    assign row_last   = (row_cnt == ROW_MAX);
    assign frame_last = win_last & col_last & row_last;
    assign early_last = S_AXIS_TLAST & ~frame_last;

    // Ready depends combinationally on downstream ready so a draining output never stalls input
    assign S_AXIS_TREADY = ARESETN & (state != DRAIN) & (~out_valid | M_AXIS_TREADY);
    assign in_beat       = S_AXIS_TVALID & S_AXIS_TREADY;
    assign out_beat      = out_valid & M_AXIS_TREADY;

    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TLAST  = out_last;
    assign FRAME_ERR     = frame_err;

    // Frame FSM, window/column/row counters, accumulator and single-entry output register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            win_cnt   <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (out_beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if ((state == DRAIN) && out_last) begin
                    state <= IDLE;
                end
            end
            if (in_beat) begin
                acc <= cur_max;
                if ((frame_last && !S_AXIS_TLAST) || early_last) begin
                    frame_err <= 1'b1;
                end
                // A reload in the same cycle as an output beat takes priority
                if (win_last || early_last) begin
                    out_data  <= cur_max;
                    out_valid <= 1'b1;
                    out_last  <= frame_last | early_last;
                end
                if (frame_last || early_last) begin
                    state   <= DRAIN;
                    win_cnt <= '0;
                    col_cnt <= '0;
                    row_cnt <= '0;
                end else begin
                    state <= ACTIVE;
                    if (win_last) begin
                        win_cnt <= '0;
                        if (col_last) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule
